// File: rtl/pc_register.sv
// Fetch-stage program counter: async reset to a vector, stall, trap redirect,
// absolute/relative redirects with alignment checking and fault-address capture.
module pc_register #(
    parameter int               WIDTH        = 32,
    parameter int               INC          = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'('h100),
    parameter int               ALIGN_BITS   = 2
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_trap,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_in,
    input  logic             i_branch,
    input  logic [WIDTH-1:0] i_offset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_out,
    output logic [WIDTH-1:0] o_next_seq,
    output logic [WIDTH-1:0] o_prev,
    output logic             o_misaligned,
    output logic [WIDTH-1:0] o_fault_addr
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);
    // Mask of low target bits that must be zero; all-zero mask disables the check.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'(1) << ALIGN_BITS) - 64'(1));

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_prev;
    logic             r_misaligned;
    logic [WIDTH-1:0] r_fault_addr;

    logic [WIDTH-1:0] w_seq;
    logic [WIDTH-1:0] w_target;
    logic             w_redirect;
    logic             w_fault;
    logic [WIDTH-1:0] w_next;

    assign w_seq      = r_out + INC_W;
    assign w_target   = i_load ? i_in : (r_out + i_offset);
    assign w_redirect = !i_trap && !i_stall && (i_load || i_branch);
    assign w_fault    = w_redirect && ((w_target & ALIGN_MASK) != '0);

    always_comb begin
        w_next = r_out;
        if (i_trap)
            w_next = TRAP_VECTOR;
        else if (i_stall)
            w_next = r_out;
        else if (w_redirect)
            w_next = w_fault ? TRAP_VECTOR : w_target;
        else if (i_inc)
            w_next = w_seq;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_out        <= RESET_VECTOR;
            r_prev       <= RESET_VECTOR;
            r_misaligned <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            r_out        <= w_next;
            r_misaligned <= w_fault;
            // prev only tracks real changes, so a held or self-redirected PC keeps its history.
            if (w_next != r_out)
                r_prev <= r_out;
            if (w_fault)
                r_fault_addr <= w_target;
        end
    end

    assign o_out        = r_out;
    assign o_next_seq   = w_seq;
    assign o_prev       = r_prev;
    assign o_misaligned = r_misaligned;
    assign o_fault_addr = r_fault_addr;

endmodule

// File: tb/tb_pc_register.sv
// Directed checks of pc_register: reset, load/inc, branch/wrap, stall/trap, alignment faults, priority.
module tb_pc_register;

    logic        clk, rst, stall, trap, load, branch, inc;
    logic [31:0] in_v, offset;
    logic [31:0] out_v, next_seq, prev, fault_addr;
    logic        mis;
    int          n_cmp = 0;
    int          n_err = 0;

    pc_register dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_stall      (stall),
        .i_trap       (trap),
        .i_load       (load),
        .i_in         (in_v),
        .i_branch     (branch),
        .i_offset     (offset),
        .i_inc        (inc),
        .o_out        (out_v),
        .o_next_seq   (next_seq),
        .o_prev       (prev),
        .o_misaligned (mis),
        .o_fault_addr (fault_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 0; trap = 0; load = 0; branch = 0; inc = 0;
        in_v = '0; offset = '0;
        #2;
        chk("reset_out", out_v, 32'h0);
        chk("reset_mis", {31'b0, mis}, 32'h0);
        tick();
        rst = 1'b0;

        // T1: async reset mid-cycle
        load = 1; in_v = 32'h20; tick();
        in_v = 32'h40; tick();
        chk("t1_pre_out", out_v, 32'h40);
        chk("t1_pre_prev", prev, 32'h20);
        load = 0;
        #2 rst = 1'b1;
        #1;
        chk("t1_async_out", out_v, 32'h0);
        chk("t1_async_prev", prev, 32'h0);
        chk("t1_async_mis", {31'b0, mis}, 32'h0);
        tick();
        rst = 1'b0;

        // T2: load then increment
        load = 1; in_v = 32'hAAA0; tick();
        chk("t2_load", out_v, 32'hAAA0);
        load = 0; inc = 1; tick();
        chk("t2_inc1", out_v, 32'hAAA4);
        tick();
        chk("t2_inc2", out_v, 32'hAAA8);
        chk("t2_prev", prev, 32'hAAA4);
        chk("t2_next_seq", next_seq, 32'hAAAC);
        inc = 0;

        // T3: negative branch, then wrap on increment
        load = 1; in_v = 32'h1000; tick();
        load = 0; branch = 1; offset = 32'hFFFF_FFF0; tick();
        chk("t3_branch", out_v, 32'h0FF0);
        chk("t3_branch_prev", prev, 32'h1000);
        branch = 0; load = 1; in_v = 32'hFFFF_FFFC; tick();
        chk("t3_top", out_v, 32'hFFFF_FFFC);
        chk("t3_next_seq_wrap", next_seq, 32'h0);
        load = 0; inc = 1; tick();
        chk("t3_wrap", out_v, 32'h0);

        // T4: stall blocks inc/load, trap overrides stall
        load = 1; in_v = 32'h80; tick();
        load = 0; stall = 1;
        tick(); tick(); tick();
        chk("t4_stall_out", out_v, 32'h80);
        load = 1; in_v = 32'h300; tick();
        chk("t4_stall_load", out_v, 32'h80);
        load = 0; trap = 1; tick();
        chk("t4_trap_stall", out_v, 32'h100);
        chk("t4_trap_prev", prev, 32'h80);
        trap = 0; stall = 0; inc = 0;

        // T5: misaligned load, one-cycle pulse, trap beats fault
        load = 1; in_v = 32'h2002; tick();
        chk("t5_mis_out", out_v, 32'h100);
        chk("t5_mis_pulse", {31'b0, mis}, 32'h1);
        chk("t5_fault_addr", fault_addr, 32'h2002);
        load = 0; tick();
        chk("t5_mis_clear", {31'b0, mis}, 32'h0);
        chk("t5_fault_hold", fault_addr, 32'h2002);
        trap = 1; load = 1; in_v = 32'h3001; tick();
        chk("t5_trap_out", out_v, 32'h100);
        chk("t5_trap_mis", {31'b0, mis}, 32'h0);
        chk("t5_trap_fault", fault_addr, 32'h2002);
        trap = 0; in_v = 32'h200; tick();
        chk("t5_aligned_load", out_v, 32'h200);
        load = 0; branch = 1; offset = 32'h6; tick();
        chk("t5_br_mis_out", out_v, 32'h100);
        chk("t5_br_mis_prev", prev, 32'h200);
        chk("t5_br_mis_pulse", {31'b0, mis}, 32'h1);
        chk("t5_br_fault", fault_addr, 32'h206);
        branch = 0;

        // T6: load beats branch and inc, idle holds
        load = 1; branch = 1; inc = 1; in_v = 32'h500; offset = 32'h8; tick();
        chk("t6_priority", out_v, 32'h500);
        chk("t6_mis", {31'b0, mis}, 32'h0);
        load = 0; branch = 0; inc = 0; tick();
        chk("t6_idle_hold", out_v, 32'h500);
        chk("t6_idle_prev", prev, 32'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
